// File: rtl/fp64_mant_mul_seq.sv
// Sequential shift-add multiplier for 53-bit FP64 mantissas, valid/ready on both sides.
// Define FP64_MUL_RADIX4_EN to retire two multiplier bits per RUN cycle.
module fp64_mant_mul_seq #(
  parameter int MW = 53,
  parameter int EW = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   ma,
  input  logic [MW-1:0]   mb,
  input  logic [EW-1:0]   exp_in,
  input  logic            sign_in,
  input  logic [2:0]      case_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*MW-1:0] mproduct,
  output logic [EW-1:0]   exp_out,
  output logic            sign_out,
  output logic [2:0]      case_out,
  output logic            busy
);

  localparam int PW = 2 * MW;
`ifdef FP64_MUL_RADIX4_EN
  localparam int STEPS = (MW + 1) / 2;
  localparam int SH    = 2;
`else
  localparam int STEPS = MW;
  localparam int SH    = 1;
`endif
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [MW-1:0] mplier;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pp;
  logic [PW-1:0] acc_nxt;
  logic          bypass;

  // Partial product for the multiplier bit(s) retired this cycle; the sum never exceeds PW bits.
  always_comb begin
    pp = '0;
    if (mplier[0]) pp = mcand;
`ifdef FP64_MUL_RADIX4_EN
    if (mplier[1]) pp = pp + {mcand[PW-2:0], 1'b0};
`endif
    acc_nxt = acc + pp;
  end

  assign bypass = (case_in != 3'd0) || (ma == '0) || (mb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mproduct  <= '0;
      exp_out   <= '0;
      sign_out  <= 1'b0;
      case_out  <= 3'd0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            exp_out  <= exp_in;
            sign_out <= sign_in;
            case_out <= case_in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (bypass) begin
              // Specials and zero operands skip the iteration entirely.
              mproduct  <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc    <= '0;
              mcand  <= {{MW{1'b0}}, ma};
              mplier <= mb;
              cnt    <= CW'(STEPS);
              state  <= RUN;
            end
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << SH;
          mplier <= mplier >> SH;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            mproduct  <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp64_mant_mul_seq.sv
// Scoreboard bench for fp64_mant_mul_seq: driver queues expected beats, monitor checks on each output handshake.
module tb_fp64_mant_mul_seq;

`ifdef FP64_MUL_RADIX4_EN
  localparam int NLAT = 28;
`else
  localparam int NLAT = 54;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [52:0]  ma, mb;
  logic [12:0]  exp_in;
  logic         sign_in;
  logic [2:0]   case_in;
  logic         out_valid;
  logic         out_ready;
  logic [105:0] mproduct;
  logic [12:0]  exp_out;
  logic         sign_out;
  logic [2:0]   case_out;
  logic         busy;

  fp64_mant_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ma(ma), .mb(mb), .exp_in(exp_in), .sign_in(sign_in), .case_in(case_in),
    .out_valid(out_valid), .out_ready(out_ready), .mproduct(mproduct),
    .exp_out(exp_out), .sign_out(sign_out), .case_out(case_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [105:0] prod;
    logic [12:0]  e;
    logic         s;
    logic [2:0]   c;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   first_cyc = 0;
  int   last_hs = -100;
  bit   prev_ov = 1'b0;

  localparam logic [105:0] ONE_SQ = 106'd1 << 104;
  localparam logic [105:0] MAX_SQ = {{52{1'b1}}, 53'd0, 1'b1};
  localparam logic [52:0]  ONE_M  = 53'd1 << 52;
  localparam logic [52:0]  MAX_M  = {53{1'b1}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [105:0] ref_mul(input logic [52:0] a, input logic [52:0] b);
    logic [105:0] wa, wb;
    wa = {53'd0, a};
    wb = {53'd0, b};
    return wa * wb;
  endfunction

  // Monitor: latency measured from the accept cycle to the first cycle out_valid is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) first_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        exp_t x;
        last_hs = cyc;
        if (q.size() == 0) begin
          check("unexpected_out", 128'(1), 128'(0));
        end else begin
          x = q.pop_front();
          check("mproduct", 128'(mproduct), 128'(x.prod));
          check("exp_out",  128'(exp_out),  128'(x.e));
          check("sign_out", 128'(sign_out), 128'(x.s));
          check("case_out", 128'(case_out), 128'(x.c));
          check("latency",  128'(first_cyc - x.acc_cyc), 128'(x.lat));
        end
      end
    end
  end

  task automatic issue(input logic [52:0] a, input logic [52:0] b, input logic [12:0] e,
                       input logic s, input logic [2:0] c, input logic [105:0] prod,
                       input int lat, input bit chk_b2b);
    exp_t x;
    bit   ok = 1'b0;
    ma = a; mb = b; exp_in = e; sign_in = s; case_in = c;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      check("accept_timeout", 128'(0), 128'(1));
    end else begin
      if (chk_b2b) check("b2b_accept_gap", 128'(cyc - last_hs), 128'(1));
      x.prod = prod; x.e = e; x.s = s; x.c = c; x.acc_cyc = cyc; x.lat = lat;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ma = '0; mb = '0; exp_in = '0; sign_in = 1'b0; case_in = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_mproduct",  128'(mproduct),  128'(0));
    check("rst_exp_out",   128'(exp_out),   128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal-path directed vectors and fixed pairs against the reference product
    issue(ONE_M, ONE_M, 13'd0, 1'b0, 3'd0, ONE_SQ, NLAT, 1'b0); in_valid = 1'b0; drain();
    issue(MAX_M, MAX_M, 13'h1FFF, 1'b1, 3'd0, MAX_SQ, NLAT, 1'b0); in_valid = 1'b0; drain();
    issue(53'h1_23456789ABCDE, 53'h1_FEDCBA9876543, 13'h0042, 1'b0, 3'd0,
          ref_mul(53'h1_23456789ABCDE, 53'h1_FEDCBA9876543), NLAT, 1'b0); in_valid = 1'b0; drain();
    issue(53'h1_0000000000001, 53'h1_8000000000000, 13'h1F00, 1'b1, 3'd0,
          ref_mul(53'h1_0000000000001, 53'h1_8000000000000), NLAT, 1'b0); in_valid = 1'b0; drain();
    issue(53'h1_5555555555555, 53'h1_AAAAAAAAAAAAA, 13'h0800, 1'b0, 3'd0,
          ref_mul(53'h1_5555555555555, 53'h1_AAAAAAAAAAAAA), NLAT, 1'b0); in_valid = 1'b0; drain();

    // Bypass paths
    issue(ONE_M, ONE_M, 13'h0123, 1'b1, 3'd2, 106'd0, 1, 1'b0); in_valid = 1'b0; drain();
    issue(53'd0, MAX_M, 13'h0007, 1'b0, 3'd0, 106'd0, 1, 1'b0); in_valid = 1'b0; drain();

    // Back-pressure: DONE held with outputs frozen, in_valid ignored
    out_ready = 1'b0;
    issue(ONE_M, MAX_M, 13'h00AB, 1'b1, 3'd0, ref_mul(ONE_M, MAX_M), NLAT, 1'b0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_wait_valid", 128'(seen), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0]; ma = MAX_M; mb = MAX_M; case_in = 3'd3;
      @(negedge clk);
      check("bp_mproduct",  128'(mproduct),  128'(ref_mul(ONE_M, MAX_M)));
      check("bp_exp_out",   128'(exp_out),   128'(13'h00AB));
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready",  128'(in_ready),  128'(0));
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after",  128'(in_ready),  128'(1));
    check("bp_out_valid_after", 128'(out_valid), 128'(0));
    check("bp_queue_empty",     128'(q.size()),  128'(0));
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    issue(ONE_M, ONE_M, 13'd0, 1'b0, 3'd0, ONE_SQ, NLAT, 1'b0);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_in_ready",  128'(in_ready),  128'(1));
    check("arst_busy",      128'(busy),      128'(0));
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(ONE_M, ONE_M, 13'd0, 1'b0, 3'd0, ONE_SQ, NLAT, 1'b0); in_valid = 1'b0; drain();

    // Back-to-back with in_valid and out_ready held high
    issue(53'h1_0F0F0F0F0F0F0, 53'h1_3333333333333, 13'h0011, 1'b0, 3'd0,
          ref_mul(53'h1_0F0F0F0F0F0F0, 53'h1_3333333333333), NLAT, 1'b0);
    issue(ONE_M, ONE_M, 13'h0022, 1'b1, 3'd1, 106'd0, 1, 1'b1);
    issue(MAX_M, MAX_M, 13'h0033, 1'b1, 3'd0, MAX_SQ, NLAT, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
